// File: rtl/fpnew_special_result_pipe.sv
// Multi-format IEEE special-result generator (qNaN / +-inf / +-zero / +-max-normal),
// NaN-boxed to Width bits and carried through an elastic valid/ready pipeline.
module fpnew_special_result_pipe #(
    parameter int unsigned Width        = 64,
    parameter int unsigned NumPipeRegs  = 1,
    parameter int unsigned TagWidth     = 4,
    parameter bit          EnableNanBox = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [2:0]          fmt_i,
    input  logic [1:0]          kind_i,
    input  logic                use_sign_i,
    input  logic                sign_i,
    input  logic [TagWidth-1:0] tag_i,
    output logic [Width-1:0]    result_o,
    output logic [TagWidth-1:0] tag_o,
    output logic                err_o,
    output logic                out_valid_o,
    input  logic                out_ready_i
);

    localparam logic [2:0] FmtFp32    = 3'd0;
    localparam logic [2:0] FmtFp64    = 3'd1;
    localparam logic [2:0] FmtFp16    = 3'd2;
    localparam logic [2:0] FmtFp8     = 3'd3;
    localparam logic [2:0] FmtFp16Alt = 3'd4;

    localparam logic [1:0] KindQnan    = 2'd0;
    localparam logic [1:0] KindInf     = 2'd1;
    localparam logic [1:0] KindZero    = 2'd2;
    localparam logic [1:0] KindMaxNorm = 2'd3;

    // Builds {box, s, exp, man} for a format with e exponent and m mantissa bits.
    function automatic logic [Width-1:0] encode(input int unsigned e, input int unsigned m,
                                                input logic [1:0] kind, input logic s);
        logic [Width-1:0] exp_ones;
        logic [Width-1:0] exp_f;
        logic [Width-1:0] man_f;
        logic [Width-1:0] box;
        logic             s_f;
        exp_ones = (Width'(1) << e) - Width'(1);
        // A shift by the full width yields zero, so FP64 in a 64-bit result gets no box bits.
        box      = EnableNanBox ? ~((Width'(1) << (e + m + 1)) - Width'(1)) : '0;
        s_f      = s;
        exp_f    = exp_ones;
        man_f    = '0;
        case (kind)
            KindQnan: begin
                s_f   = 1'b0;
                man_f = Width'(1) << (m - 1);
            end
            KindInf:  man_f = '0;
            KindZero: exp_f = '0;
            KindMaxNorm: begin
                exp_f = exp_ones - Width'(1);
                man_f = (Width'(1) << m) - Width'(1);
            end
        endcase
        return box | (Width'(s_f) << (e + m)) | (exp_f << m) | man_f;
    endfunction

    logic [Width-1:0] enc_res_c;
    logic             enc_err_c;
    logic             enc_sign_c;

    // Special-result encoder for the incoming request.
    always_comb begin
        enc_res_c  = '1;
        enc_err_c  = 1'b0;
        enc_sign_c = use_sign_i & sign_i;
        case (fmt_i)
            FmtFp32:    enc_res_c = encode(8, 23, kind_i, enc_sign_c);
            FmtFp64:    enc_res_c = encode(11, 52, kind_i, enc_sign_c);
            FmtFp16:    enc_res_c = encode(5, 10, kind_i, enc_sign_c);
            FmtFp8:     enc_res_c = encode(5, 2, kind_i, enc_sign_c);
            FmtFp16Alt: enc_res_c = encode(8, 7, kind_i, enc_sign_c);
            default: begin
                enc_res_c = '1;
                enc_err_c = 1'b1;
            end
        endcase
    end

    if (NumPipeRegs == 0) begin : g_comb
        assign in_ready_o  = out_ready_i & ~rst_i;
        assign out_valid_o = in_valid_i & ~rst_i;
        assign result_o    = enc_res_c;
        assign tag_o       = tag_i;
        assign err_o       = enc_err_c;
    end else begin : g_pipe
        localparam int unsigned N = NumPipeRegs;

        logic [N-1:0]               v_q, v_d;
        logic [N-1:0][Width-1:0]    res_q, res_d;
        logic [N-1:0][TagWidth-1:0] tag_q, tag_d;
        logic [N-1:0]               err_q, err_d;
        logic [N:0]                 rdy_c;

        // Stage i may load when it is empty or anything downstream of it can move.
        always_comb begin
            logic acc;
            acc      = out_ready_i;
            rdy_c    = '0;
            rdy_c[N] = acc;
            for (int i = N - 1; i >= 0; i--) begin
                acc      = ~v_q[i] | acc;
                rdy_c[i] = acc;
            end
        end

        always_comb begin
            v_d   = v_q;
            res_d = res_q;
            tag_d = tag_q;
            err_d = err_q;
            if (rdy_c[0]) begin
                v_d[0]   = in_valid_i;
                res_d[0] = enc_res_c;
                tag_d[0] = tag_i;
                err_d[0] = enc_err_c;
            end
            for (int i = 1; i < N; i++) begin
                if (rdy_c[i]) begin
                    v_d[i]   = v_q[i-1];
                    res_d[i] = res_q[i-1];
                    tag_d[i] = tag_q[i-1];
                    err_d[i] = err_q[i-1];
                end
            end
            // Flush drops every in-flight entry, including a request handshaked this cycle.
            if (flush_i) begin
                v_d = '0;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                v_q   <= '0;
                res_q <= '0;
                tag_q <= '0;
                err_q <= '0;
            end else begin
                v_q   <= v_d;
                res_q <= res_d;
                tag_q <= tag_d;
                err_q <= err_d;
            end
        end

        assign in_ready_o  = rdy_c[0] & ~rst_i;
        assign out_valid_o = v_q[N-1] & ~rst_i;
        assign result_o    = res_q[N-1];
        assign tag_o       = tag_q[N-1];
        assign err_o       = err_q[N-1];
    end

endmodule
